// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - CU/ALU-facing signal bundle of the ALU issue stage
interface alu_dispatch_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_dat;
  logic [31:0] rs2_dat;
  logic [31:0] imm;

  logic [31:0] alu_dat1;
  logic [31:0] alu_dat2;
  logic [2:0]  alu_opcode;
  logic        alu_diff;
  logic        alu_optype;
  logic        alu_dat_ready;
  logic [31:0] alu_out;
  logic [4:0]  alu_flags;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_dat;
  logic [4:0]  res_flags;
  logic        res_illegal;

  // Dispatcher side
  modport slave (
    input  instr_valid, instr, rs1_dat, rs2_dat, imm,
    input  alu_out, alu_flags, res_ready,
    output instr_ready, alu_dat1, alu_dat2, alu_opcode, alu_diff, alu_optype,
    output alu_dat_ready, res_valid, res_dat, res_flags, res_illegal
  );

  // CU + ALU side
  modport master (
    output instr_valid, instr, rs1_dat, rs2_dat, imm,
    output alu_out, alu_flags, res_ready,
    input  instr_ready, alu_dat1, alu_dat2, alu_opcode, alu_diff, alu_optype,
    input  alu_dat_ready, res_valid, res_dat, res_flags, res_illegal
  );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - ALU issue stage: decode, hold operands for ALU_LATENCY, capture result
// Optional perf counters built when ALU_DISPATCH_PERF_EN is defined.
module alu_dispatch #(
  parameter int ALU_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic         soc_clk,
  input  logic         reset_b,
  alu_dispatch_if.slave dif,
  output logic [31:0]  perf_issued,
  output logic [31:0]  perf_stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dat1_q, dat1_d;
  logic [31:0]      dat2_q, dat2_d;
  logic [2:0]       opc_q, opc_d;
  logic             diff_q, diff_d;
  logic             optype_q, optype_d;
  logic [31:0]      res_dat_q, res_dat_d;
  logic [4:0]       res_flags_q, res_flags_d;
  logic             res_illegal_q, res_illegal_d;

  logic [6:0]  dec_opc;
  logic [2:0]  dec_funct3;
  logic        dec_b30;
  logic        dec_legal;
  logic [31:0] dec_dat2;
  logic        dec_optype;
  logic        dec_diff;
  logic        accept;
  logic        unused_instr_bits;

  assign dec_opc    = dif.instr[6:0];
  assign dec_funct3 = dif.instr[14:12];
  assign dec_b30    = dif.instr[30];
  assign unused_instr_bits = ^{dif.instr[31], dif.instr[29:15], dif.instr[11:7]};

  // instr[30] selects SUB/SRA for R-type, but only SRAI for I-type (ADDI's imm may set it)
  always_comb begin
    dec_legal  = 1'b1;
    dec_dat2   = dif.rs2_dat;
    dec_optype = 1'b1;
    dec_diff   = 1'b0;
    case (dec_opc)
      OPC_R: dec_diff = dec_b30 & ((dec_funct3 == 3'b000) | (dec_funct3 == 3'b101));
      OPC_I: begin
        dec_dat2 = dif.imm;
        dec_diff = dec_b30 & (dec_funct3 == 3'b101);
      end
      OPC_B: dec_optype = 1'b0;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dif.instr_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & dif.res_ready);
  assign accept          = dif.instr_valid & dif.instr_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dat1_d        = dat1_q;
    dat2_d        = dat2_q;
    opc_d         = opc_q;
    diff_d        = diff_q;
    optype_d      = optype_q;
    res_dat_d     = res_dat_q;
    res_flags_d   = res_flags_q;
    res_illegal_d = res_illegal_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (dec_legal) begin
            dat1_d   = dif.rs1_dat;
            dat2_d   = dec_dat2;
            opc_d    = dec_funct3;
            diff_d   = dec_diff;
            optype_d = dec_optype;
            cnt_d    = '0;
            state_d  = ST_BUSY;
          end else begin
            res_dat_d     = '0;
            res_flags_d   = '0;
            res_illegal_d = 1'b1;
            state_d       = ST_DONE;
          end
        end else if (state_q == ST_DONE && dif.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          // Branches only report through the flags; the data word is meaningless
          res_dat_d     = optype_q ? dif.alu_out : 32'd0;
          res_flags_d   = dif.alu_flags;
          res_illegal_d = 1'b0;
          cnt_d         = '0;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge soc_clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dat1_q        <= '0;
      dat2_q        <= '0;
      opc_q         <= '0;
      diff_q        <= 1'b0;
      optype_q      <= 1'b0;
      res_dat_q     <= '0;
      res_flags_q   <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dat1_q        <= dat1_d;
      dat2_q        <= dat2_d;
      opc_q         <= opc_d;
      diff_q        <= diff_d;
      optype_q      <= optype_d;
      res_dat_q     <= res_dat_d;
      res_flags_q   <= res_flags_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  // dat_ready decodes straight from state so an async reset drops it immediately
  assign dif.alu_dat_ready = (state_q == ST_BUSY);
  assign dif.alu_dat1      = dat1_q;
  assign dif.alu_dat2      = dat2_q;
  assign dif.alu_opcode    = opc_q;
  assign dif.alu_diff      = diff_q;
  assign dif.alu_optype    = optype_q;
  assign dif.res_valid     = (state_q == ST_DONE);
  assign dif.res_dat       = res_dat_q;
  assign dif.res_flags     = res_flags_q;
  assign dif.res_illegal   = res_illegal_q;

`ifdef ALU_DISPATCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (accept && dec_legal) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    if (state_q == ST_DONE && !dif.res_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge soc_clk or negedge reset_b) begin
    if (!reset_b) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`else
  assign perf_issued = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed bench for alu_dispatch with a behavioural ALU
module tb_alu_dispatch;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] OPC_L = 7'b0000011;

  logic        soc_clk;
  logic        reset_b;
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
  int          n_checks;
  int          n_fail;
  int          lat;
  int          hi;

  alu_dispatch_if bus ();

  alu_dispatch #(.ALU_LATENCY(2), .CNT_W(4)) dut (
    .soc_clk     (soc_clk),
    .reset_b     (reset_b),
    .dif         (bus.slave),
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
  );

  function automatic logic [36:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input logic diff,
                                            input logic optype);
    logic [31:0] r;
    logic        br;
    r  = '0;
    br = 1'b0;
    if (optype) begin
      case (op)
        3'b000: r = diff ? a - b : a + b;
        3'b001: r = a << b[4:0];
        3'b010: r = {31'd0, $signed(a) < $signed(b)};
        3'b011: r = {31'd0, a < b};
        3'b100: r = a ^ b;
        3'b101: r = diff ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'b110: r = a | b;
        default: r = a & b;
      endcase
    end else begin
      r = a - b;
      case (op)
        3'b000: br = (a == b);
        3'b001: br = (a != b);
        3'b100: br = ($signed(a) < $signed(b));
        3'b101: br = ($signed(a) >= $signed(b));
        3'b110: br = (a < b);
        3'b111: br = (a >= b);
        default: br = 1'b0;
      endcase
    end
    return {1'b0, 1'b0, br, (r == 32'd0), r[31], r};
  endfunction

  assign {bus.alu_flags, bus.alu_out} =
      alu_model(bus.alu_dat1, bus.alu_dat2, bus.alu_opcode, bus.alu_diff, bus.alu_optype);

  initial begin
    soc_clk = 1'b0;
    forever #5 soc_clk = ~soc_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic b30, input logic [2:0] f3, input logic [6:0] opc);
    return {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic drive_op(input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.rs1_dat     = a;
    bus.rs2_dat     = b;
    bus.imm         = im;
    @(negedge soc_clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_res(output int l, output int h);
    l = 1;
    h = 0;
    while (!bus.res_valid && l < 40) begin
      if (bus.alu_dat_ready) h++;
      @(negedge soc_clk);
      l++;
    end
    check("res_valid_timeout", bus.res_valid, 1);
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    repeat (2) @(negedge soc_clk);
    reset_b = 1'b1;
    @(negedge soc_clk);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset_b         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.rs1_dat     = '0;
    bus.rs2_dat     = '0;
    bus.imm         = '0;
    bus.res_ready   = 1'b1;
    repeat (2) @(negedge soc_clk);

    check("rst_instr_ready", bus.instr_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_dat_ready", bus.alu_dat_ready, 0);
    check("rst_alu_dat1", bus.alu_dat1, 0);
    check("rst_res_dat", bus.res_dat, 0);
    check("rst_res_illegal", bus.res_illegal, 0);
    check("rst_perf_issued", perf_issued, 0);
    check("rst_perf_stall", perf_stall, 0);
    reset_b = 1'b1;
    @(negedge soc_clk);

    // ADD 5 + 7
    drive_op(mk(1'b0, 3'b000, OPC_R), 32'd5, 32'd7, 32'd0);
    check("add_dat_ready", bus.alu_dat_ready, 1);
    check("add_dat1", bus.alu_dat1, 32'd5);
    check("add_dat2", bus.alu_dat2, 32'd7);
    check("add_opcode", bus.alu_opcode, 0);
    check("add_diff", bus.alu_diff, 0);
    check("add_optype", bus.alu_optype, 1);
    check("add_busy_instr_ready", bus.instr_ready, 0);
    wait_res(lat, hi);
    check("add_latency", lat, 3);
    check("add_dat_ready_cycles", hi, 2);
    check("add_res_dat", bus.res_dat, 32'd12);
    check("add_res_illegal", bus.res_illegal, 0);
    check("add_done_dat_ready", bus.alu_dat_ready, 0);
    @(negedge soc_clk);
    check("add_retired_valid", bus.res_valid, 0);
    check("add_idle_instr_ready", bus.instr_ready, 1);

    // SUB 5 - 7
    drive_op(mk(1'b1, 3'b000, OPC_R), 32'd5, 32'd7, 32'd0);
    check("sub_diff", bus.alu_diff, 1);
    wait_res(lat, hi);
    check("sub_res_dat", bus.res_dat, 32'hFFFF_FFFE);
    @(negedge soc_clk);

    // SLL with instr[30] set: diff must stay 0
    drive_op(mk(1'b1, 3'b001, OPC_R), 32'd1, 32'd4, 32'd0);
    check("sll_diff", bus.alu_diff, 0);
    check("sll_opcode", bus.alu_opcode, 3'b001);
    wait_res(lat, hi);
    check("sll_res_dat", bus.res_dat, 32'd16);
    @(negedge soc_clk);

    // SRAI 0x80000000 >>> 4
    drive_op(mk(1'b1, 3'b101, OPC_I), 32'h8000_0000, 32'h55, 32'h404);
    check("srai_diff", bus.alu_diff, 1);
    check("srai_dat2", bus.alu_dat2, 32'h404);
    wait_res(lat, hi);
    check("srai_res_dat", bus.res_dat, 32'hF800_0000);
    @(negedge soc_clk);

    // ADDI with instr[30] set (imm bit 10): diff must stay 0
    drive_op(mk(1'b1, 3'b000, OPC_I), 32'd1, 32'h55, 32'h400);
    check("addi_diff", bus.alu_diff, 0);
    check("addi_dat2", bus.alu_dat2, 32'h400);
    wait_res(lat, hi);
    check("addi_res_dat", bus.res_dat, 32'h401);
    @(negedge soc_clk);

    // BEQ taken
    drive_op(mk(1'b0, 3'b000, OPC_B), 32'h10, 32'h10, 32'd0);
    check("beq_optype", bus.alu_optype, 0);
    check("beq_diff", bus.alu_diff, 0);
    check("beq_dat2", bus.alu_dat2, 32'h10);
    wait_res(lat, hi);
    check("beq_res_dat", bus.res_dat, 0);
    check("beq_branch_flag", bus.res_flags[2], 1);
    @(negedge soc_clk);

    // BNE not taken
    drive_op(mk(1'b0, 3'b001, OPC_B), 32'h10, 32'h10, 32'd0);
    wait_res(lat, hi);
    check("bne_branch_flag", bus.res_flags[2], 0);
    check("bne_res_dat", bus.res_dat, 0);
    @(negedge soc_clk);

    // Illegal load opcode
    drive_op(mk(1'b0, 3'b010, OPC_L), 32'd1, 32'd2, 32'd3);
    check("ill_dat_ready", bus.alu_dat_ready, 0);
    check("ill_res_valid", bus.res_valid, 1);
    check("ill_res_illegal", bus.res_illegal, 1);
    check("ill_res_dat", bus.res_dat, 0);
    check("ill_res_flags", bus.res_flags, 0);
    @(negedge soc_clk);
    check("ill_retired", bus.res_valid, 0);
    drive_op(mk(1'b0, 3'b110, OPC_R), 32'h0F, 32'hF0, 32'd0);
    wait_res(lat, hi);
    check("or_after_ill_illegal", bus.res_illegal, 0);
    check("or_after_ill_res_dat", bus.res_dat, 32'hFF);
    @(negedge soc_clk);

    // Back-pressure with a pending op
    do_reset();
    bus.res_ready = 1'b0;
    drive_op(mk(1'b0, 3'b000, OPC_R), 32'd3, 32'd4, 32'd0);
    wait_res(lat, hi);
    check("bp_first_latency", lat, 3);
    bus.instr_valid = 1'b1;
    bus.instr       = mk(1'b0, 3'b100, OPC_R);
    bus.rs1_dat     = 32'hF0;
    bus.rs2_dat     = 32'hFF;
    for (int k = 0; k < 5; k++) begin
      check("bp_instr_ready", bus.instr_ready, 0);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_dat", bus.res_dat, 32'd7);
      check("bp_dat_ready", bus.alu_dat_ready, 0);
      @(negedge soc_clk);
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_release_instr_ready", bus.instr_ready, 1);
    @(negedge soc_clk);
    bus.instr_valid = 1'b0;
    check("bp_new_dat_ready", bus.alu_dat_ready, 1);
    check("bp_new_dat1", bus.alu_dat1, 32'hF0);
    check("bp_old_retired", bus.res_valid, 0);
`ifdef ALU_DISPATCH_PERF_EN
    check("bp_perf_stall", perf_stall, 32'd5);
    check("bp_perf_issued", perf_issued, 32'd2);
`else
    check("bp_perf_stall_tied", perf_stall, 32'd0);
    check("bp_perf_issued_tied", perf_issued, 32'd0);
`endif
    wait_res(lat, hi);
    check("bp_second_res_dat", bus.res_dat, 32'h0F);
    @(negedge soc_clk);

    // Reset in second BUSY cycle
    drive_op(mk(1'b0, 3'b000, OPC_R), 32'd5, 32'd7, 32'd0);
    @(negedge soc_clk);
    check("mid_busy_dat_ready", bus.alu_dat_ready, 1);
    reset_b = 1'b0;
    #1;
    check("mid_rst_dat_ready", bus.alu_dat_ready, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_instr_ready", bus.instr_ready, 1);
    @(negedge soc_clk);
    reset_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge soc_clk);
      check("post_rst_res_valid", bus.res_valid, 0);
      check("post_rst_instr_ready", bus.instr_ready, 1);
      check("post_rst_dat_ready", bus.alu_dat_ready, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
